// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC scheduler.
package cordic_pkg;

    localparam int W = 32;

    // Result selector codes.
    localparam logic [2:0] SEL_SIN     = 3'd0;
    localparam logic [2:0] SEL_COS     = 3'd1;
    localparam logic [2:0] SEL_ARCTAN  = 3'd2;
    localparam logic [2:0] SEL_SINH    = 3'd3;
    localparam logic [2:0] SEL_COSH    = 3'd4;
    localparam logic [2:0] SEL_ARCTANH = 3'd5;
    localparam logic [2:0] SEL_EXP     = 3'd6;
    localparam logic [2:0] SEL_ILLEGAL = 3'd7;

    // Named bits of the 5-bit CORDIC mode word (C H R V E, MSB first).
    localparam logic [4:0] CHRVE_C          = 5'b10000;
    localparam logic [4:0] CHRVE_H          = 5'b01000;
    localparam logic [4:0] CHRVE_R          = 5'b00100;
    localparam logic [4:0] CHRVE_V          = 5'b00010;
    localparam logic [4:0] CHRVE_E          = 5'b00001;
    localparam logic [4:0] CHRVE_SINCOS_EXP = 5'b00101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic sel_is_legal(input logic [2:0] sel);
        return sel != SEL_ILLEGAL;
    endfunction

endpackage

// File: rtl/cordic_scheduler_if.sv
// Request/response bundle between requesters and the CORDIC scheduler.
interface cordic_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int W     = cordic_pkg::W
) ();
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [W*N_REQ-1:0] req_y;
    logic [W*N_REQ-1:0] req_z;
    logic [5*N_REQ-1:0] req_chrve;
    logic [3*N_REQ-1:0] req_sel;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [W-1:0]       rsp_data;
    logic               rsp_err;

    modport master (
        output req_valid, req_y, req_z, req_chrve, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_y, req_z, req_chrve, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    // First pass covers indices >= ptr; the second pass wraps to the low indices.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_any && i_req[i] && (i >= int'(i_ptr))) begin
                o_any    = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = IW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_any && i_req[i]) begin
                o_any    = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Time-shares one CORDIC core among N_REQ requesters: grant, hold operands
// for LAT cycles, capture the selected result and return it with the owner id.
module cordic_scheduler #(
    parameter int N_REQ = 4,
    parameter int LAT   = 32,
    parameter int W     = cordic_pkg::W
) (
    input  logic             clk,
    input  logic             rst,
    cordic_scheduler_if.slave bus,
    output logic [W-1:0]     o_cordic_y,
    output logic [W-1:0]     o_cordic_z,
    output logic [4:0]       o_cordic_chrve,
    input  logic [W-1:0]     i_sin,
    input  logic [W-1:0]     i_cos,
    input  logic [W-1:0]     i_arctan_y,
    input  logic [W-1:0]     i_sinh,
    input  logic [W-1:0]     i_cosh,
    input  logic [W-1:0]     i_arctanh_y,
    input  logic [W-1:0]     i_exp
);
    import cordic_pkg::*;

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LAT + 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  r_gid;
    logic [IW-1:0]  r_rsp_id;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_y;
    logic [W-1:0]   r_z;
    logic [4:0]     r_chrve;
    logic [2:0]     r_sel;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_err;

    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]    w_gidx;
    logic             w_any;
    logic             w_accept;
    logic             w_capture;
    logic             w_done;
    logic [W-1:0]     w_req_y;
    logic [W-1:0]     w_req_z;
    logic [4:0]       w_req_chrve;
    logic [2:0]       w_req_sel;
    logic [W-1:0]     w_sel_data;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    // Pick the winning requester's operand slices.
    always_comb begin
        w_req_y     = '0;
        w_req_z     = '0;
        w_req_chrve = '0;
        w_req_sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_req_y     = bus.req_y[i*W +: W];
                w_req_z     = bus.req_z[i*W +: W];
                w_req_chrve = bus.req_chrve[i*5 +: 5];
                w_req_sel   = bus.req_sel[i*3 +: 3];
            end
        end
    end

    // Select the core output named by the latched selector; illegal gives 0.
    always_comb begin
        w_sel_data = '0;
        case (r_sel)
            SEL_SIN:     w_sel_data = i_sin;
            SEL_COS:     w_sel_data = i_cos;
            SEL_ARCTAN:  w_sel_data = i_arctan_y;
            SEL_SINH:    w_sel_data = i_sinh;
            SEL_COSH:    w_sel_data = i_cosh;
            SEL_ARCTANH: w_sel_data = i_arctanh_y;
            SEL_EXP:     w_sel_data = i_exp;
            default:     w_sel_data = '0;
        endcase
    end

    // Next-state and handshake decode; ready is masked while reset is held so
    // a pending requester never sees a strobe that cannot be honoured.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_done        = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst) begin
                    bus.req_ready = w_gnt;
                end
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == CW'(1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Latch the winner on accept and count the settle time down in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= '0;
            r_z     <= '0;
            r_chrve <= '0;
            r_sel   <= '0;
            r_gid   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_y     <= w_req_y;
            r_z     <= w_req_z;
            r_chrve <= w_req_chrve;
            r_sel   <= w_req_sel;
            r_gid   <= w_gidx;
            r_cnt   <= CW'(LAT);
        end else if (r_state == ST_HOLD) begin
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    // Capture the response on the last HOLD edge; it stays put through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_id   <= '0;
        end else if (w_capture) begin
            r_rsp_data <= w_sel_data;
            r_rsp_err  <= !sel_is_legal(r_sel);
            r_rsp_id   <= r_gid;
        end
    end

    // Rotation pointer advances only when a response completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_ptr <= '0;
        else if (w_done) r_ptr <= (r_gid == IW'(N_REQ - 1)) ? '0 : r_gid + 1'b1;
    end

    assign o_cordic_y     = r_y;
    assign o_cordic_z     = r_z;
    assign o_cordic_chrve = r_chrve;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Self-checking bench for cordic_scheduler: table vectors, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_cordic_scheduler;
    import cordic_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 32;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] s_core [8];
    logic [31:0] cy, cz, cy1, cz1;
    logic [4:0]  cc, cc1;

    cordic_scheduler_if #(.N_REQ(N), .W(DW)) bus  ();
    cordic_scheduler_if #(.N_REQ(N), .W(DW)) bus1 ();

    cordic_scheduler #(.N_REQ(N), .LAT(LAT), .W(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_cordic_y(cy), .o_cordic_z(cz), .o_cordic_chrve(cc),
        .i_sin(s_core[0]), .i_cos(s_core[1]), .i_arctan_y(s_core[2]), .i_sinh(s_core[3]),
        .i_cosh(s_core[4]), .i_arctanh_y(s_core[5]), .i_exp(s_core[6])
    );

    cordic_scheduler #(.N_REQ(N), .LAT(1), .W(DW)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .o_cordic_y(cy1), .o_cordic_z(cz1), .o_cordic_chrve(cc1),
        .i_sin(s_core[0]), .i_cos(s_core[1]), .i_arctan_y(s_core[2]), .i_sinh(s_core[3]),
        .i_cosh(s_core[4]), .i_arctanh_y(s_core[5]), .i_exp(s_core[6])
    );

    // requester-side state
    logic [N-1:0] pv;
    logic [31:0]  py [N];
    logic [31:0]  pz [N];
    logic [4:0]   pc [N];
    logic [2:0]   ps [N];

    // transaction-level model
    bit          m_busy;
    int          m_acc, m_own, m_ptr, first_vld;
    logic [31:0] m_y, m_z, m_data, n_y, n_z;
    logic [4:0]  m_c, n_c;
    bit          m_err;
    int          cyc;
    int          acc_log[$];
    int          d_log[$];
    int          d_cyc[$];

    int n_pass, n_tot, n_fail;

    typedef struct {
        int          id;
        logic [31:0] y;
        logic [31:0] z;
        logic [4:0]  c;
        logic [2:0]  s;
        logic [31:0] ed;
        bit          ee;
    } vec_t;
    vec_t tv [8];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, got, exp);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [32:0] result_of(input logic [2:0] sel);
        if (sel == 3'd7) return {1'b1, 32'h0};
        return {1'b0, s_core[sel]};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_ptr = 0; m_y = '0; m_z = '0; m_c = '0; first_vld = -1;
    endtask

    task automatic set_req(input int id, input logic [31:0] y, input logic [31:0] z,
                           input logic [4:0] c, input logic [2:0] s);
        pv[id] = 1'b1; py[id] = y; pz[id] = z; pc[id] = c; ps[id] = s;
    endtask

    task automatic drive();
        bus.req_valid = pv;
        for (int i = 0; i < N; i++) begin
            bus.req_y[i*32 +: 32]   = py[i];
            bus.req_z[i*32 +: 32]   = pz[i];
            bus.req_chrve[i*5 +: 5] = pc[i];
            bus.req_sel[i*3 +: 3]   = ps[i];
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, compare to model.
    task automatic tick(input bit rr);
        int w;
        logic [N-1:0] er;
        @(negedge clk);
        drive();
        bus.rsp_ready = rr;
        #1;
        cyc++;
        if (|bus.req_ready) begin
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) w = i;
            d_log.push_back(w);
            d_cyc.push_back(cyc);
        end
        if (m_busy && cyc == m_acc + 1) begin m_y = n_y; m_z = n_z; m_c = n_c; end
        chk("cordic_y", cy, m_y);
        chk("cordic_z", cz, m_z);
        chk("cordic_chrve", cc, m_c);
        if (!m_busy) begin
            er = '0;
            w = winner(pv, m_ptr);
            if (w >= 0) er[w] = 1'b1;
            chk("req_ready", bus.req_ready, er);
            chk("rsp_valid_idle", bus.rsp_valid, 0);
            if (w >= 0) begin
                m_busy = 1'b1; m_acc = cyc; m_own = w; first_vld = -1;
                n_y = py[w]; n_z = pz[w]; n_c = pc[w];
                {m_err, m_data} = result_of(ps[w]);
                acc_log.push_back(w);
                pv[w] = 1'b0;
            end
        end else begin
            chk("req_ready_busy", bus.req_ready, 0);
            if (bus.rsp_valid === 1'b1 && first_vld < 0) first_vld = cyc;
            if (cyc <= m_acc + LAT) chk("rsp_valid_hold", bus.rsp_valid, 0);
            else begin
                chk("rsp_valid", bus.rsp_valid, 1);
                chk("rsp_id", bus.rsp_id, m_own);
                chk("rsp_data", bus.rsp_data, m_data);
                chk("rsp_err", bus.rsp_err, m_err);
                if (rr) begin m_busy = 1'b0; m_ptr = (m_own + 1) % N; end
            end
        end
    endtask

    task automatic run_to_accept(input bit rr);
        int n0;
        n0 = acc_log.size();
        for (int i = 0; i < 200 && acc_log.size() == n0; i++) tick(rr);
        if (acc_log.size() == n0) chk("accept_timeout", 0, 1);
    endtask

    task automatic run_to_valid();
        for (int i = 0; i < 200 && !(m_busy && cyc > m_acc + LAT); i++) tick(1'b0);
        if (!(m_busy && cyc > m_acc + LAT)) chk("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (m_busy || pv != '0); i++) tick(1'b1);
        if (m_busy || pv != '0) chk("drain_timeout", 0, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_id"},    bus.rsp_id, 0);
        chk({tag, "_rsp_data"},  bus.rsp_data, 0);
        chk({tag, "_rsp_err"},   bus.rsp_err, 0);
        chk({tag, "_cordic_y"},  cy, 0);
        chk({tag, "_cordic_z"},  cz, 0);
        chk({tag, "_cordic_c"},  cc, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, t_rdy;
        bit reissued;
        logic [31:0] snap_d, snap_z;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        tv[0] = '{0, 32'h0,        32'h41F00000, CHRVE_SINCOS_EXP, 3'd0, 32'h3F000000, 1'b0};
        tv[1] = '{2, 32'h3F800000, 32'h3F000000, CHRVE_SINCOS_EXP, 3'd7, 32'h00000000, 1'b1};
        tv[2] = '{1, 32'h0,        32'h41F00000, CHRVE_SINCOS_EXP, 3'd1, 32'h3F5DB3D7, 1'b0};
        tv[3] = '{3, 32'h3F800000, 32'h0,        5'b10010,         3'd2, 32'h3F490FDB, 1'b0};
        tv[4] = '{0, 32'h0,        32'h3F800000, CHRVE_SINCOS_EXP, 3'd6, 32'h402DF854, 1'b0};
        tv[5] = '{2, 32'h0,        32'h3F800000, 5'b01100,         3'd4, 32'h3FC583AB, 1'b0};
        tv[6] = '{1, 32'h0,        32'h3F800000, 5'b01100,         3'd3, 32'h3F966CFE, 1'b0};
        tv[7] = '{3, 32'h3F000000, 32'h0,        5'b01010,         3'd5, 32'h3F0C9F54, 1'b0};

        s_core[0] = 32'h3F000000; s_core[1] = 32'h3F5DB3D7; s_core[2] = 32'h3F490FDB;
        s_core[3] = 32'h3F966CFE; s_core[4] = 32'h3FC583AB; s_core[5] = 32'h3F0C9F54;
        s_core[6] = 32'h402DF854; s_core[7] = 32'h0;
        n_pass = 0; n_tot = 0; n_fail = 0; cyc = 0;
        pv = '0;
        for (int i = 0; i < N; i++) begin py[i] = '0; pz[i] = '0; pc[i] = '0; ps[i] = '0; end
        bus.rsp_ready = 1'b0;
        bus1.req_valid = '0; bus1.req_y = '0; bus1.req_z = '0;
        bus1.req_chrve = '0; bus1.req_sel = '0; bus1.rsp_ready = 1'b1;
        drive();
        model_reset();
        rst = 1'b1;
        #7;
        chk_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // table vectors, one requester at a time
        for (int i = 0; i < 8; i++) begin
            set_req(tv[i].id, tv[i].y, tv[i].z, tv[i].c, tv[i].s);
            run_to_accept(1'b1);
            chk("tv_grant", d_log.size() > 0 ? d_log[$] : -1, tv[i].id);
            run_to_valid();
            chk("tv_latency", first_vld - m_acc, LAT + 1);
            chk("tv_data", bus.rsp_data, tv[i].ed);
            chk("tv_err", bus.rsp_err, tv[i].ee);
            chk("tv_id", bus.rsp_id, tv[i].id);
            chk("tv_hold_z", cz, tv[i].z);
            tick(1'b1);
        end

        // LAT=1 instance: accept at T, response at T+2
        @(negedge clk);
        bus1.req_valid = 4'b0010;
        bus1.req_sel[5:3] = 3'd6;
        bus1.req_z[63:32] = 32'h3F800000;
        bus1.req_chrve[9:5] = CHRVE_SINCOS_EXP;
        #1;
        chk("lat1_ready", bus1.req_ready, 4'b0010);
        @(negedge clk); bus1.req_valid = '0; #1;
        chk("lat1_hold_z", cz1, 32'h3F800000);
        chk("lat1_vld_t1", bus1.rsp_valid, 0);
        @(negedge clk); #1;
        chk("lat1_vld_t2", bus1.rsp_valid, 1);
        chk("lat1_data", bus1.rsp_data, 32'h402DF854);
        chk("lat1_id", bus1.rsp_id, 1);
        chk("lat1_err", bus1.rsp_err, 0);
        @(negedge clk); #1;
        chk("lat1_done", bus1.rsp_valid, 0);

        // all four at once: 0,1,2,3 then 0 again, 34 cycles apart
        for (int i = 0; i < N; i++) set_req(i, 32'(i), 32'h40000000 + 32'(i), CHRVE_SINCOS_EXP, 3'(i));
        n0 = d_log.size();
        reissued = 1'b0;
        for (int k = 0; k < 400 && d_log.size() < n0 + 5; k++) begin
            tick(1'b1);
            if (!reissued && d_log.size() > n0) begin
                set_req(0, 32'h11111111, 32'h22222222, CHRVE_SINCOS_EXP, 3'd6);
                reissued = 1'b1;
            end
        end
        if (d_log.size() < n0 + 5) chk("grant_count", d_log.size() - n0, 5);
        else begin
            for (int k = 0; k < 5; k++) chk("grant_order", d_log[n0 + k], exp_order[k]);
            for (int k = 1; k < 5; k++) chk("grant_spacing", d_cyc[n0 + k] - d_cyc[n0 + k - 1], LAT + 2);
        end
        drain();

        // back-pressure: 10 extra cycles with rsp_ready low, requester 3 waiting
        set_req(2, 32'h3F800000, 32'h40400000, 5'b01100, 3'd4);
        run_to_accept(1'b1);
        set_req(3, 32'h3F000000, 32'h3E800000, CHRVE_SINCOS_EXP, 3'd0);
        run_to_valid();
        snap_d = bus.rsp_data; snap_z = cz;
        n0 = d_log.size();
        repeat (10) tick(1'b0);
        chk("bp_data", bus.rsp_data, snap_d);
        chk("bp_cordic_z", cz, snap_z);
        chk("bp_no_grant", d_log.size(), n0);
        chk("bp_valid", bus.rsp_valid, 1);
        tick(1'b1);
        t_rdy = cyc;
        run_to_accept(1'b1);
        chk("bp_next_grant", d_log.size() > n0 ? d_log[$] : -1, 3);
        chk("bp_resume", d_log.size() > n0 ? d_cyc[$] - t_rdy : -1, 1);
        drain();

        // reset in HOLD cycle 5; pointer must return to 0
        set_req(0, 32'h0, 32'h3F800000, CHRVE_SINCOS_EXP, 3'd1);
        run_to_accept(1'b1);
        drain();
        set_req(1, 32'h12345678, 32'h9ABCDEF0, CHRVE_SINCOS_EXP, 3'd0);
        set_req(0, 32'h0, 32'h41200000, CHRVE_SINCOS_EXP, 3'd1);
        set_req(2, 32'h0, 32'h41300000, CHRVE_SINCOS_EXP, 3'd2);
        run_to_accept(1'b1);
        chk("rst_pre_grant", d_log[$], 1);
        repeat (4) tick(1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        n0 = d_log.size();
        run_to_accept(1'b1);
        chk("rst_first_grant", d_log.size() > n0 ? d_log[$] : -1, 0);
        drain();

        // randomized traffic
        for (int i = 0; i < 7; i++) s_core[i] = $urandom();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++)
                if (!pv[i] && $urandom_range(3) == 0)
                    set_req(i, $urandom(), $urandom(), 5'($urandom()), 3'($urandom()));
            tick($urandom_range(3) != 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
